lamp_ctrl_arb: RTL and testbench
================================

Name: lamp_ctrl_arb

Overview:
- Multi-way lamp controller. N_BTN wall buttons share one lamp output, as in a stairwell.
- Each raw button is synchronised and debounced, and produces a single press event.
- Simultaneous press events are arbitrated to one winner. Each accepted press toggles the lamp.
- An auto-off timer turns the lamp off after TIMEOUT_CYC cycles, preceded by a blinking warning window.

Parameters:
- N_BTN, 4: number of button inputs (≥1).
- DB_CYC, 16: consecutive stable synchronised samples needed to accept a level change (≥1).
- TIMEOUT_CYC, 1000: cycles spent in ON before entering WARN (≥1).
- WARN_CYC, 100: cycles spent in WARN before auto-off (≥2*BLINK_HALF).
- BLINK_HALF, 10: half-period of the warning blink, in cycles (≥1).

Ports:
- clk  in  1: single clock, rising edge.
- rst  in  1: asynchronous, active-low reset.
- btn  in  N_BTN: raw asynchronous button levels, 1 = pressed.
- L  out  1: physical lamp drive; blinks during WARN.
- lamp_on  out  1: logical lamp state, 1 in ON and in WARN.
- owner  out  max(1,$clog2(N_BTN)): index of the button that last turned the lamp on.
- toggle_pulse  out  1: one-cycle pulse for every accepted press.
- timeout_pulse  out  1: one-cycle pulse on auto-off.

Behaviour:
- Reset (rst=0, asynchronous):
  - State OFF; all counters cleared.
  - L=0, lamp_on=0, owner=0, toggle_pulse=0, timeout_pulse=0.
  - Sync flops cleared; debounced levels set to 1 (treated as pressed). A button held through reset therefore must be released and pressed again before it generates a press.
- Per-button front end:
  - 2-flop synchroniser produces s.
  - Counter increments while s≠db and clears while s=db. When it reaches DB_CYC, db takes the value of s and the counter clears.
  - press = db & ~db_q: one cycle wide, on the cycle after db rises.
- Latency: for a raw rising level stable from sampling edge E, db rises at edge E+1+DB_CYC and state, L and lamp_on change at edge E+2+DB_CYC. A level pulse shorter than DB_CYC samples is ignored.
- Arbitration:
  - If several press events occur in one cycle, the lowest index wins. The rest are discarded, not queued.
  - Exactly one toggle_pulse is produced per such cycle.
- FSM, registered state, 2 bits:
  - OFF: L=0, lamp_on=0.
    - press → ON; timer=TIMEOUT_CYC-1; owner=grant index; toggle_pulse.
  - ON: L=1, lamp_on=1; timer decrements each cycle.
    - press → OFF; toggle_pulse; owner holds.
    - Otherwise timer==0 → WARN; timer=WARN_CYC-1; blink counter cleared.
  - WARN: lamp_on=1. L=0 for the first BLINK_HALF cycles, then alternates every BLINK_HALF cycles.
    - press → ON; timer=TIMEOUT_CYC-1; owner=grant index; toggle_pulse. A press extends the lamp, it does not turn it off.
    - Otherwise timer==0 → OFF; timeout_pulse.
  - Illegal state encoding → OFF.
- Simultaneous events: a press and a timer expiry in the same cycle resolve in favour of the press.
- Outputs: all registered. toggle_pulse and timeout_pulse are never high together.
- Timer width: $clog2(max(TIMEOUT_CYC,WARN_CYC)). No wrap; the timer only decrements while above 0.
- Reset mid-operation: rst asserted in any state forces OFF outputs immediately, without waiting for a clock edge.

Decomposition:
- Package lamp_ctrl_pkg holds:
  - state typedef: 2-bit enum LC_OFF=0, LC_ON=1, LC_WARN=2.
  - helper function for counter widths.
- Sub-module btn_debounce (parameter DB_CYC; ports clk, rst, raw, press) contains the synchroniser, the debounce counter and the rising-edge detect.
  - Instantiated N_BTN times through a generate loop.
  - Arbiter, timer and FSM stay in lamp_ctrl_arb.

Test Plan (DB_CYC=4, TIMEOUT_CYC=20, WARN_CYC=8, BLINK_HALF=2, N_BTN=4):
1. Held through reset: btn[0]=1 during and after reset release → no toggle. Then release for 6 cycles and press again → L=1, lamp_on=1, owner=0, one toggle_pulse, with L rising exactly 6 edges after the press is sampled.
2. Glitch rejection: btn[1] high for 3 cycles, then low → L stays 0, no toggle_pulse.
3. Simultaneous presses: btn[2] and btn[3] rise together from OFF → owner=2, single toggle_pulse, L=1. Then btn[3] press/release → OFF, owner stays 2.
4. Timeout: press btn[1], no further input → L=1 for 20 cycles, then L pattern 0,0,1,1,0,0,1,1 with lamp_on=1 throughout; then OFF with one timeout_pulse.
5. Extend: press btn[3] during the 3rd WARN cycle → ON, L=1, owner=3, full 20-cycle ON window before WARN again. A press landing on the WARN timer==0 cycle gives ON, not OFF.
6. Async reset: assert rst mid-WARN between clock edges → L=0, lamp_on=0, owner=0 immediately. After release with all buttons low, no spurious toggle occurs.

Source files
------------

// File: rtl/lamp_ctrl_pkg.sv
// Shared types and sizing helpers for the stairwell lamp controller.
package lamp_ctrl_pkg;

   typedef enum logic [1:0] {
      LC_OFF  = 2'd0,
      LC_ON   = 2'd1,
      LC_WARN = 2'd2
   } lc_state_t;

   // Bits needed to hold the values 0..v-1, never less than one bit.
   function automatic int cw(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One wall button: 2-flop synchroniser, debounce counter and press detect.
// Debounced level resets to "pressed" so a button held through reset
// must be released before it can produce a press.
module btn_debounce
   import lamp_ctrl_pkg::*;
#(
   parameter int DB_CYC = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic press
);

   localparam int CW = cw(DB_CYC);

   logic          s1, s2;
   logic          db, db_q;
   logic [CW-1:0] cnt;

   // Synchronise, then accept a new level after DB_CYC consecutive differing samples.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         db   <= 1'b1;
         db_q <= 1'b1;
         cnt  <= '0;
      end else begin
         s1   <= raw;
         s2   <= s1;
         db_q <= db;
         if (s2 == db) begin
            cnt <= '0;
         end else if (cnt == CW'(DB_CYC - 1)) begin
            db  <= s2;
            cnt <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   assign press = db & ~db_q;

endmodule

// File: rtl/lamp_ctrl_arb.sv
// Multi-way lamp controller: N_BTN debounced buttons, lowest-index
// arbitration, toggle FSM with auto-off timer and blinking warning window.
module lamp_ctrl_arb
   import lamp_ctrl_pkg::*;
#(
   parameter  int N_BTN       = 4,
   parameter  int DB_CYC      = 16,
   parameter  int TIMEOUT_CYC = 1000,
   parameter  int WARN_CYC    = 100,
   parameter  int BLINK_HALF  = 10,
   localparam int OW          = cw(N_BTN)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn,
   output logic             L,
   output logic             lamp_on,
   output logic [OW-1:0]    owner,
   output logic             toggle_pulse,
   output logic             timeout_pulse
);

   localparam int TW = cw(imax(TIMEOUT_CYC, WARN_CYC));
   localparam int BW = cw(BLINK_HALF);

   logic [N_BTN-1:0] press;
   logic             any_press;
   logic [OW-1:0]    grant;

   lc_state_t        state, state_n;
   logic [TW-1:0]    timer, timer_n;
   logic [BW-1:0]    blink, blink_n;
   logic             l_n, lamp_on_n, tog_n, tout_n;
   logic [OW-1:0]    owner_n;

   genvar i;
   generate
      for (i = 0; i < N_BTN; i++) begin : g_btn
         btn_debounce #(.DB_CYC(DB_CYC)) u_db (
            .clk   (clk),
            .rst   (rst),
            .raw   (btn[i]),
            .press (press[i])
         );
      end
   endgenerate

   // Lowest index wins; losing presses in the same cycle are dropped.
   always_comb begin
      any_press = 1'b0;
      grant     = '0;
      for (int k = N_BTN - 1; k >= 0; k--) begin
         if (press[k]) begin
            any_press = 1'b1;
            grant     = OW'(k);
         end
      end
   end

   // Register state, timers and every output so nothing glitches off-chip.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= LC_OFF;
         timer         <= '0;
         blink         <= '0;
         L             <= 1'b0;
         lamp_on       <= 1'b0;
         owner         <= '0;
         toggle_pulse  <= 1'b0;
         timeout_pulse <= 1'b0;
      end else begin
         state         <= state_n;
         timer         <= timer_n;
         blink         <= blink_n;
         L             <= l_n;
         lamp_on       <= lamp_on_n;
         owner         <= owner_n;
         toggle_pulse  <= tog_n;
         timeout_pulse <= tout_n;
      end
   end

   // Next state and next outputs; a press always beats a timer expiry.
   always_comb begin
      state_n = state;
      timer_n = timer;
      blink_n = blink;
      l_n     = L;
      owner_n = owner;
      tog_n   = 1'b0;
      tout_n  = 1'b0;
      case (state)
         LC_OFF: begin
            l_n = 1'b0;
            if (any_press) begin
               state_n = LC_ON;
               timer_n = TW'(TIMEOUT_CYC - 1);
               owner_n = grant;
               tog_n   = 1'b1;
               l_n     = 1'b1;
            end
         end
         LC_ON: begin
            if (any_press) begin
               state_n = LC_OFF;
               timer_n = '0;
               tog_n   = 1'b1;
               l_n     = 1'b0;
            end else if (timer == '0) begin
               state_n = LC_WARN;
               timer_n = TW'(WARN_CYC - 1);
               blink_n = '0;
               l_n     = 1'b0;
            end else begin
               timer_n = timer - TW'(1);
            end
         end
         LC_WARN: begin
            if (any_press) begin
               state_n = LC_ON;
               timer_n = TW'(TIMEOUT_CYC - 1);
               owner_n = grant;
               tog_n   = 1'b1;
               l_n     = 1'b1;
            end else if (timer == '0) begin
               state_n = LC_OFF;
               tout_n  = 1'b1;
               l_n     = 1'b0;
            end else begin
               timer_n = timer - TW'(1);
               if (blink == BW'(BLINK_HALF - 1)) begin
                  blink_n = '0;
                  l_n     = ~L;
               end else begin
                  blink_n = blink + BW'(1);
               end
            end
         end
         default: begin
            state_n = LC_OFF;
            timer_n = '0;
            blink_n = '0;
            l_n     = 1'b0;
         end
      endcase
      lamp_on_n = (state_n == LC_ON) || (state_n == LC_WARN);
   end

endmodule

// File: tb/tb_lamp_ctrl_arb.sv
// Directed bench for lamp_ctrl_arb with a cycle-level behavioural model.
module tb_lamp_ctrl_arb;

   localparam int N = 4, DB = 4, TO = 20, WC = 8, BH = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] btn = 4'b0;
   logic       L, lamp_on, toggle_pulse, timeout_pulse;
   logic [1:0] owner;

   int total = 0, bad = 0, tog_cnt = 0, tout_cnt = 0;

   lamp_ctrl_arb #(
      .N_BTN(N), .DB_CYC(DB), .TIMEOUT_CYC(TO), .WARN_CYC(WC), .BLINK_HALF(BH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .btn           (btn),
      .L             (L),
      .lamp_on       (lamp_on),
      .owner         (owner),
      .toggle_pulse  (toggle_pulse),
      .timeout_pulse (timeout_pulse)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: mode 0=off 1=on 2=warn, m_left = cycles remaining in the phase,
   // m_elap = cycles already spent in warn.
   logic [3:0] m_s1 = 4'b0, m_s2 = 4'b0, m_db = 4'hF, m_dbq = 4'hF, m_pr;
   int         m_run[4] = '{default: 0};
   int         m_mode = 0, m_left = 0, m_elap = 0, m_owner = 0, m_g;
   int         m_tog = 0, m_tout = 0;

   function automatic int exp_l();
      if (m_mode == 1) return 1;
      if (m_mode == 2) return (m_elap / BH) % 2;
      return 0;
   endfunction

   initial forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
         m_s1 = 4'b0; m_s2 = 4'b0; m_db = 4'hF; m_dbq = 4'hF;
         for (int i = 0; i < 4; i++) m_run[i] = 0;
         m_mode = 0; m_left = 0; m_elap = 0; m_owner = 0; m_tog = 0; m_tout = 0;
      end else begin
         m_pr = m_db & ~m_dbq;
         m_g  = -1;
         for (int i = 3; i >= 0; i--) if (m_pr[i]) m_g = i;
         m_tog = 0; m_tout = 0;
         if (m_g >= 0) begin
            m_tog = 1;
            if (m_mode == 1) m_mode = 0;
            else begin m_mode = 1; m_left = TO; m_owner = m_g; end
         end else if (m_mode == 1) begin
            m_left--;
            if (m_left == 0) begin m_mode = 2; m_left = WC; m_elap = 0; end
         end else if (m_mode == 2) begin
            m_left--; m_elap++;
            if (m_left == 0) begin m_mode = 0; m_tout = 1; end
         end
         m_dbq = m_db;
         for (int i = 0; i < 4; i++) begin
            if (m_s2[i] != m_db[i]) begin
               m_run[i]++;
               if (m_run[i] == DB) begin m_db[i] = m_s2[i]; m_run[i] = 0; end
            end else m_run[i] = 0;
         end
         m_s2 = m_s1;
         m_s1 = btn;
      end
   end

   // Compare DUT outputs with the model every cycle.
   initial forever begin
      @(negedge clk);
      chk("L", L, exp_l());
      chk("lamp_on", lamp_on, (m_mode != 0) ? 1 : 0);
      chk("owner", owner, m_owner);
      chk("toggle_pulse", toggle_pulse, m_tog);
      chk("timeout_pulse", timeout_pulse, m_tout);
      chk("pulse_excl", toggle_pulse & timeout_pulse, 0);
      if (toggle_pulse === 1'b1) tog_cnt++;
      if (timeout_pulse === 1'b1) tout_cnt++;
   end

   task automatic wait_l(input logic want, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (L !== want && n < 60);
      chk("wait_L", L, want);
   endtask

   initial begin
      int n, t0, cnt;
      logic [7:0] pat;
      // 1: held through reset, then a real press
      rst = 1'b0; btn = 4'b0001;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (10) @(negedge clk);
      chk("t1_held_no_toggle", tog_cnt, 0);
      chk("t1_held_L", L, 0);
      btn = 4'b0000; repeat (6) @(negedge clk);
      btn = 4'b0001; wait_l(1'b1, n);
      chk("t1_latency", n, 7);
      chk("t1_owner", owner, 0);
      chk("t1_lamp_on", lamp_on, 1);
      @(negedge clk);
      chk("t1_toggles", tog_cnt, 1);
      btn = 4'b0000; repeat (8) @(negedge clk);
      btn = 4'b0001; repeat (8) @(negedge clk);
      btn = 4'b0000; repeat (8) @(negedge clk);
      chk("t1_off_L", L, 0);
      chk("t1_toggles2", tog_cnt, 2);
      // 2: glitch rejection
      t0 = tog_cnt;
      btn = 4'b0010; repeat (3) @(negedge clk);
      btn = 4'b0000; repeat (12) @(negedge clk);
      chk("t2_no_toggle", tog_cnt, t0);
      chk("t2_L", L, 0);
      // 3: simultaneous presses
      btn = 4'b1100; wait_l(1'b1, n);
      chk("t3_latency", n, 7);
      chk("t3_owner", owner, 2);
      @(negedge clk);
      chk("t3_single_toggle", tog_cnt, t0 + 1);
      btn = 4'b0000; repeat (8) @(negedge clk);
      btn = 4'b1000; repeat (8) @(negedge clk);
      btn = 4'b0000; repeat (8) @(negedge clk);
      chk("t3_off_L", L, 0);
      chk("t3_owner_hold", owner, 2);
      chk("t3_toggles", tog_cnt, t0 + 2);
      // 4: timeout with warning blink
      btn = 4'b0010; wait_l(1'b1, n);
      chk("t4_owner", owner, 1);
      btn = 4'b0000;
      cnt = 0;
      while (L === 1'b1 && cnt < 100) begin cnt++; @(negedge clk); end
      chk("t4_on_len", cnt, 20);
      for (int i = 0; i < 8; i++) begin
         pat[i] = L;
         chk("t4_warn_lamp_on", lamp_on, 1);
         @(negedge clk);
      end
      chk("t4_blink_pattern", pat, 8'hCC);
      chk("t4_off_lamp_on", lamp_on, 0);
      chk("t4_timeout_pulse", timeout_pulse, 1);
      chk("t4_no_toggle", toggle_pulse, 0);
      @(negedge clk);
      chk("t4_timeout_count", tout_cnt, 1);
      // 5: extend during warning
      btn = 4'b0001; wait_l(1'b1, n);
      chk("t5_owner0", owner, 0);
      btn = 4'b0000;
      for (int c = 2; c <= 23; c++) begin
         @(negedge clk);
         if (c == 17) btn = 4'b1000;
         if (c == 21) begin
            chk("t5_warn1_L", L, 0);
            chk("t5_warn1_lamp_on", lamp_on, 1);
         end
      end
      @(negedge clk);
      chk("t5_ext_L", L, 1);
      chk("t5_ext_owner", owner, 3);
      chk("t5_ext_toggle", toggle_pulse, 1);
      btn = 4'b0000;
      cnt = 0;
      while (L === 1'b1 && cnt < 100) begin cnt++; @(negedge clk); end
      chk("t5_full_on_len", cnt, 20);
      for (int c = 22; c <= 28; c++) begin
         @(negedge clk);
         if (c == 22) btn = 4'b0100;
      end
      chk("t5_last_warn_lamp_on", lamp_on, 1);
      @(negedge clk);
      chk("t5_edge_L", L, 1);
      chk("t5_edge_lamp_on", lamp_on, 1);
      chk("t5_edge_no_timeout", timeout_pulse, 0);
      chk("t5_edge_owner", owner, 2);
      btn = 4'b0000;
      // 6: asynchronous reset mid-warning
      cnt = 0;
      while (!(lamp_on === 1'b1 && L === 1'b0) && cnt < 100) begin cnt++; @(negedge clk); end
      chk("t6_in_warn", lamp_on, 1);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("t6_async_L", L, 0);
      chk("t6_async_lamp_on", lamp_on, 0);
      chk("t6_async_owner", owner, 0);
      @(negedge clk);
      t0 = tog_cnt;
      @(negedge clk);
      rst = 1'b1;
      repeat (15) @(negedge clk);
      chk("t6_no_spurious", tog_cnt, t0);
      chk("t6_L", L, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
